// File: rtl/ble_pkg.sv
// ble_pkg: shared BLE CRC constants and checker FSM encoding.
package ble_pkg;
  localparam logic [23:0] BLE_CRC_POLY = 24'h00065B;
  localparam logic [23:0] BLE_ADV_CRC_INIT = 24'h555555;
  localparam int CRC_LEN = 24;
  typedef enum logic [1:0] {IDLE, PDU, CRC} state_e;
endpackage

// File: rtl/ble_crc_lfsr.sv
// ble_crc_lfsr: 24-bit BLE CRC register with load, feedback advance and zero-fill shift.
module ble_crc_lfsr import ble_pkg::*; #(
  parameter logic [23:0] INIT_VAL = BLE_ADV_CRC_INIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [23:0] init_i,
  input  logic        adv_i,
  input  logic        shift_i,
  input  logic        din_i,
  output logic        msb_o,
  output logic [23:0] next_o
);
  logic [23:0] lfsr_q, lfsr_d;
  logic fb;
  assign fb = din_i ^ lfsr_q[23];
  always_comb
    lfsr_d = load_i  ? init_i :
             adv_i   ? {lfsr_q[22:0], 1'b0} ^ ({24{fb}} & BLE_CRC_POLY) :
             shift_i ? {lfsr_q[22:0], 1'b0} : lfsr_q;
  always_ff @(posedge clk)
    lfsr_q <= rst ? INIT_VAL : lfsr_d;
  assign msb_o = lfsr_q[23];
  assign next_o = lfsr_d;
endmodule

// File: rtl/ble_crc_check.sv
// ble_crc_check: RX-side BLE CRC checker over a serial PDU followed by its MSB-first CRC field.
module ble_crc_check import ble_pkg::*; #(
  parameter logic [23:0] INIT_VAL = BLE_ADV_CRC_INIT,
  parameter int LEN_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] pdu_len,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic [23:0]      crc_calc
);
  localparam int CNT_W = LEN_W + 3;
  state_e state_q;
  logic [CNT_W-1:0] cnt_q;
  logic mismatch_q, done_q, crc_ok_q;
  logic [23:0] crc_calc_q, lfsr_nxt;
  logic msb, adv, shift, last, miss, empty;
  assign adv = bit_valid & ~start & (state_q == PDU);
  assign shift = bit_valid & ~start & (state_q == CRC);
  assign last = cnt_q == CNT_W'(1);
  assign miss = bit_in ^ msb;
  assign empty = pdu_len == '0;
  ble_crc_lfsr #(.INIT_VAL(INIT_VAL)) u_lfsr (
    .clk(clk), .rst(rst), .load_i(start), .init_i(INIT_VAL),
    .adv_i(adv), .shift_i(shift), .din_i(bit_in),
    .msb_o(msb), .next_o(lfsr_nxt)
  );
  // An empty PDU leaves the register at its preset, so that is the computed CRC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      mismatch_q <= 1'b0;
      done_q <= 1'b0;
      crc_ok_q <= 1'b0;
      crc_calc_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        state_q <= empty ? CRC : PDU;
        cnt_q <= empty ? CNT_W'(CRC_LEN) : {pdu_len, 3'b000};
        mismatch_q <= 1'b0;
        crc_ok_q <= 1'b0;
        if (empty) crc_calc_q <= INIT_VAL;
      end else if (adv) begin
        cnt_q <= last ? CNT_W'(CRC_LEN) : cnt_q - 1'b1;
        if (last) begin
          crc_calc_q <= lfsr_nxt;
          state_q <= CRC;
        end
      end else if (shift) begin
        cnt_q <= cnt_q - 1'b1;
        mismatch_q <= mismatch_q | miss;
        if (last) begin
          done_q <= 1'b1;
          crc_ok_q <= ~(mismatch_q | miss);
          state_q <= IDLE;
        end
      end
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign crc_ok = crc_ok_q;
  assign crc_calc = crc_calc_q;
endmodule

// File: tb/tb_ble_crc_check.sv
// tb_ble_crc_check: directed/random checks of ble_crc_check against a polynomial-division CRC model.
module tb_ble_crc_check;
  import ble_pkg::*;
  logic clk = 1'b0;
  logic rst, start, bit_in, bit_valid;
  logic [8:0] pdu_len;
  logic busy, done, crc_ok;
  logic [23:0] crc_calc;
  int n_cmp = 0, n_bad = 0;
  int gaps, busy_cyc;
  logic [7:0] pdu[$];
  logic bits[$];
  logic [23:0] c;
  ble_crc_check dut (
    .clk(clk), .rst(rst), .start(start), .pdu_len(pdu_len), .bit_in(bit_in),
    .bit_valid(bit_valid), .busy(busy), .done(done), .crc_ok(crc_ok), .crc_calc(crc_calc)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // CRC as remainder of the bit stream over the generator, seeded with init.
  function automatic logic [23:0] ref_crc(input logic [23:0] init);
    logic [23:0] r = init;
    foreach (pdu[k]) begin
      logic [7:0] bv = pdu[k];
      for (int i = 0; i < 8; i++)
        r = {r[22:0], 1'b0} ^ ((bv[i] ^ r[23]) ? BLE_CRC_POLY : 24'h0);
    end
    return r;
  endfunction
  task automatic build(input logic [23:0] crc);
    bits.delete();
    foreach (pdu[k]) begin
      logic [7:0] bv = pdu[k];
      for (int i = 0; i < 8; i++) bits.push_back(bv[i]);
    end
    for (int i = 23; i >= 0; i--) bits.push_back(crc[i]);
  endtask
  task automatic arm(input int n);
    start = 1'b1;
    pdu_len = 9'(n);
    bit_valid = 1'($urandom_range(1));
    bit_in = 1'($urandom_range(1));
    tick();
    start = 1'b0;
    bit_valid = 1'b0;
    gaps = 0;
    busy_cyc = 0;
  endtask
  task automatic run(input int gap_pct, input int upto);
    for (int i = 0; i < upto; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        bit_valid = 1'b0;
        if (busy) busy_cyc++;
        gaps++;
        tick();
      end
      bit_valid = 1'b1;
      bit_in = bits[i];
      if (busy) busy_cyc++;
      tick();
      if (i != bits.size() - 1) chk("no_early_done", 24'(done), 24'h0);
    end
    bit_valid = 1'b0;
  endtask
  task automatic check_pkt(input string tag, input logic ok, input logic [23:0] calc);
    chk({tag, "_done"}, 24'(done), 24'h1);
    chk({tag, "_ok"}, 24'(crc_ok), 24'(ok));
    chk({tag, "_calc"}, crc_calc, calc);
    chk({tag, "_idle"}, 24'(busy), 24'h0);
    tick();
    chk({tag, "_done_once"}, 24'(done), 24'h0);
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; pdu_len = '0;
    tick(); tick();
    chk("rst_busy", 24'(busy), 24'h0);
    chk("rst_done", 24'(done), 24'h0);
    chk("rst_ok", 24'(crc_ok), 24'h0);
    chk("rst_calc", crc_calc, 24'h0);
    rst = 1'b0;
    tick();
    // empty PDU: the CRC field must equal the preset
    pdu.delete();
    build(24'h555555);
    arm(0);
    chk("armed_busy", 24'(busy), 24'h1);
    run(0, bits.size());
    check_pkt("len0", 1'b1, 24'h555555);
    build(24'h555555 ^ 24'h800000);
    arm(0);
    run(0, bits.size());
    check_pkt("len0_bad", 1'b0, 24'h555555);
    // two zero bytes with gaps; busy spans every bit and gap
    pdu = '{8'h00, 8'h00};
    c = ref_crc(BLE_ADV_CRC_INIT);
    build(c);
    arm(2);
    run(30, bits.size());
    chk("busy_cycles", 24'(busy_cyc), 24'(40 + gaps));
    check_pkt("zero2", 1'b1, c);
    // random 6-byte PDUs, good CRC then a single flipped PDU bit
    for (int it = 0; it < 4; it++) begin
      int idx;
      pdu.delete();
      for (int k = 0; k < 6; k++) pdu.push_back(8'($urandom));
      c = ref_crc(BLE_ADV_CRC_INIT);
      build(c);
      arm(6);
      run(50, bits.size());
      check_pkt("rand6", 1'b1, c);
      idx = $urandom_range(47);
      bits[idx] = ~bits[idx];
      arm(6);
      run(50, bits.size());
      chk("flip_done", 24'(done), 24'h1);
      chk("flip_ok", 24'(crc_ok), 24'h0);
      tick();
    end
    // abort mid-PDU with a fresh empty-PDU packet
    pdu.delete();
    for (int k = 0; k < 3; k++) pdu.push_back(8'($urandom));
    build(ref_crc(BLE_ADV_CRC_INIT));
    arm(3);
    run(20, 10);
    pdu.delete();
    build(24'h555555);
    arm(0);
    chk("abort_busy", 24'(busy), 24'h1);
    chk("abort_no_done", 24'(done), 24'h0);
    run(20, bits.size());
    check_pkt("abort", 1'b1, 24'h555555);
    // reset in the CRC phase, then stray bits without start
    pdu = '{8'($urandom)};
    build(ref_crc(BLE_ADV_CRC_INIT));
    arm(1);
    run(0, 18);
    chk("crc_phase_busy", 24'(busy), 24'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 24'(busy), 24'h0);
    chk("midrst_done", 24'(done), 24'h0);
    chk("midrst_ok", 24'(crc_ok), 24'h0);
    chk("midrst_calc", crc_calc, 24'h0);
    run(0, bits.size());
    chk("stray_done", 24'(done), 24'h0);
    chk("stray_busy", 24'(busy), 24'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
